dm_sized: RTL

Parametrised data memory for the pipelined CPU, successor to the word-only data memory. Adds byte/halfword/word access with byte-lane merging on stores and sign/zero extension on loads. Adds alignment and range checking with an exception flag. Adds a configurable wait-state count behind a req/ready handshake so the pipeline's stall logic can be exercised. With `LATENCY=0` it is a zero-wait drop-in for the MEM stage.

---
 rtl/dm_sized.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dm_sized.sv
// rtl/dm_sized.sv - byte/half/word data memory with range checks and optional wait states
// LATENCY=0 answers combinationally; LATENCY>=1 runs an IDLE/BUSY/DONE handshake.
module dm_sized #(
  parameter int ADDR_W      = 14,
  parameter int DEPTH_WORDS = 3072,
  parameter int LATENCY     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        exc
);

  localparam int IW = ADDR_W - 2;

  logic [31:0] mem [DEPTH_WORDS];

  // Access fields: live inputs in zero-wait mode, latched request otherwise
  logic        f_we;
  logic [1:0]  f_size;
  logic        f_sext;
  logic [31:0] f_addr;
  logic [31:0] f_wdata;
  logic [31:0] f_pc;

  logic [IW-1:0] idx;
  logic          idx_ok;
  logic          bad;
  logic          commit;
  logic [31:0]   cur;
  logic [31:0]   merged;
  logic [31:0]   ld;
  logic [31:0]   res;
  logic [7:0]    sel_b;
  logic [15:0]   sel_h;

  assign idx = f_addr[ADDR_W-1:2];

  always_comb begin
    idx_ok = (32'(idx) < DEPTH_WORDS);
    bad    = (f_size == 2'b11)
           | ((f_size == 2'b01) & f_addr[0])
           | ((f_size == 2'b10) & (f_addr[1:0] != 2'b00))
           | ~idx_ok
           | ((f_addr >> ADDR_W) != 32'd0);
    cur    = idx_ok ? mem[idx] : 32'd0;

    merged = cur;
    case (f_size)
      2'b00:   merged[{f_addr[1:0], 3'b000} +: 8] = f_wdata[7:0];
      2'b01:   merged[{f_addr[1], 4'b0000} +: 16] = f_wdata[15:0];
      default: merged = f_wdata;
    endcase

    sel_b = cur[{f_addr[1:0], 3'b000} +: 8];
    sel_h = cur[{f_addr[1], 4'b0000} +: 16];
    case (f_size)
      2'b00:   ld = {{24{f_sext & sel_b[7]}}, sel_b};
      2'b01:   ld = {{16{f_sext & sel_h[15]}}, sel_h};
      default: ld = cur;
    endcase

    res = (bad | f_we) ? 32'd0 : ld;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else if (commit) begin
      mem[idx] <= merged;
`ifndef SYNTHESIS
      $display("%d@%h: *%h <= %h", $time, f_pc, {f_addr[31:2], 2'b00}, merged);
`endif
    end
  end

  if (LATENCY == 0) begin : g_comb
    assign f_we    = we;
    assign f_size  = size;
    assign f_sext  = sext;
    assign f_addr  = addr;
    assign f_wdata = wdata;
    assign f_pc    = pc;
    assign ready   = req & ~rst;
    assign rdata   = res;
    assign exc     = bad;
    assign commit  = req & we & ~bad & ~rst;
  end else begin : g_fsm
    localparam int CW = $clog2(LATENCY + 2);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic        q_we;
    logic [1:0]  q_size;
    logic        q_sext;
    logic [31:0] q_addr;
    logic [31:0] q_wdata;
    logic [31:0] q_pc;

    assign f_we    = q_we;
    assign f_size  = q_size;
    assign f_sext  = q_sext;
    assign f_addr  = q_addr;
    assign f_wdata = q_wdata;
    assign f_pc    = q_pc;
    assign commit  = (state == BUSY) & (cnt == CW'(1)) & q_we & ~bad & ~rst;

    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= IDLE;
        cnt     <= '0;
        ready   <= 1'b0;
        rdata   <= 32'd0;
        exc     <= 1'b0;
        q_we    <= 1'b0;
        q_size  <= 2'b00;
        q_sext  <= 1'b0;
        q_addr  <= 32'd0;
        q_wdata <= 32'd0;
        q_pc    <= 32'd0;
      end else begin
        case (state)
          IDLE: begin
            ready <= 1'b0;
            if (req) begin
              q_we    <= we;
              q_size  <= size;
              q_sext  <= sext;
              q_addr  <= addr;
              q_wdata <= wdata;
              q_pc    <= pc;
              cnt     <= CW'(LATENCY);
              state   <= BUSY;
            end
          end
          BUSY: begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              rdata <= res;
              exc   <= bad;
              ready <= 1'b1;
              state <= DONE;
            end
          end
          default: begin
            ready <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
